// File: rtl/lsu_mem_port.sv
// RV32I data-memory port: lane-aligns stores, builds byte enables, runs the
// req/gnt/rvalid handshake and right-justifies load data for the extender.
module lsu_mem_port #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       selector,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic [WIDTH-1:0] load_data,
    output logic             done,
    output logic             stall,
    output logic             misaligned,
    output logic             timeout_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic size_t size_of(input logic [2:0] sel);
        case (sel)
            3'd1, 3'd3: size_of = SZ_HALF;
            3'd2, 3'd4: size_of = SZ_BYTE;
            default:    size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] o);
        case (sz)
            SZ_HALF: is_misaligned = o[0];
            SZ_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (o != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] o);
        case (sz)
            SZ_HALF: byte_en = 4'b0011 << o;
            SZ_BYTE: byte_en = 4'b0001 << o;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lane_data(input size_t sz, input logic [WIDTH-1:0] d);
        case (sz)
            SZ_HALF: lane_data = {2{d[15:0]}};
            SZ_BYTE: lane_data = {4{d[7:0]}};
            default: lane_data = d;
        endcase
    endfunction

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [1:0]       off_q;
    logic [WIDTH-1:0] load_data_q;
    logic             done_q;
    logic             mis_q;
    logic             to_q;
    logic             req_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q;
    logic [3:0]       be_q;
    logic [WIDTH-1:0] wdata_q;

    size_t            sz_d;
    logic [1:0]       off_d;
    logic             mis_d;
    logic [3:0]       be_d;
    logic [WIDTH-1:0] wdata_d;
    logic             finish_d;
    logic             expire_d;

    always_comb begin
        sz_d    = size_of(selector);
        off_d   = addr[1:0];
        mis_d   = is_misaligned(sz_d, off_d);
        be_d    = byte_en(sz_d, off_d);
        wdata_d = lane_data(sz_d, store_data);
        // A response in the same cycle as the last counted cycle wins over the abort.
        finish_d = ((state_q == S_REQ) && mem_gnt && mem_rvalid) ||
                   ((state_q == S_WAIT) && mem_rvalid);
        expire_d = ((state_q == S_REQ) || (state_q == S_WAIT)) && !finish_d &&
                   (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'b00;
            load_data_q <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            to_q        <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
        end else if (finish_d) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q)
                load_data_q <= mem_rdata >> {off_q, 3'b000};
        end else if (expire_d) begin
            state_q     <= S_DONE;
            req_q       <= 1'b0;
            done_q      <= 1'b1;
            to_q        <= 1'b1;
            load_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= {addr[WIDTH-1:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        off_q   <= off_d;
                        cnt_q   <= 8'd0;
                        if (mis_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (mem_gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    to_q    <= 1'b0;
                end
            endcase
        end
    end

    assign load_data   = load_data_q;
    assign done        = done_q;
    assign misaligned  = mis_q;
    assign timeout_err = to_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign stall       = req_valid & ~done_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a hand-driven memory responder.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  selector;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        timeout_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    lsu_mem_port #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .selector(selector), .addr(addr), .store_data(store_data),
        .load_data(load_data), .done(done), .stall(stall),
        .misaligned(misaligned), .timeout_err(timeout_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] sd);
        req_valid  = 1'b1;
        req_we     = we;
        selector   = sel;
        addr       = a;
        store_data = sd;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; selector = 3'd0;
        addr = 32'h0; store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        #2;
        total++;
        if ({done, misaligned, timeout_err, mem_req, mem_we, stall} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {done, misaligned, timeout_err, mem_req, mem_we, stall});
        end
        total++;
        if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            bad++;
            $display("FAIL reset_data: load=%h addr=%h wdata=%h be=%b want all 0",
                     load_data, mem_addr, mem_wdata, mem_be);
        end
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_lbu();
        step();
        issue(1'b0, 3'd4, 32'h0000_1003, 32'h0);
        mem_rdata = 32'hAB00_0000;
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL lbu_c0: stall=%b req=%b want 1 0", stall, mem_req);
        end
        step(); mem_gnt = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h1000 || mem_we !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL lbu_c1: req=%b be=%b addr=%h we=%b stall=%b want 1 1000 00001000 0 1",
                     mem_req, mem_be, mem_addr, mem_we, stall);
        end
        step(); mem_gnt = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL lbu_c2: req=%b stall=%b done=%b want 0 1 0", mem_req, stall, done);
        end
        step(); mem_rvalid = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL lbu_c3: done=%b stall=%b want 0 1", done, stall);
        end
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h0000_00AB || stall !== 1'b0 || misaligned !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL lbu_c4: done=%b load=%h stall=%b mis=%b to=%b want 1 000000ab 0 0 0",
                     done, load_data, stall, misaligned, timeout_err);
        end
        req_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL lbu_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_half_store();
        step();
        issue(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF);
        step(); mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_we !== 1'b1 || mem_addr !== 32'h2000) begin
            bad++;
            $display("FAIL sh_bus: req=%b be=%b wdata=%h we=%b addr=%h want 1 1100 beefbeef 1 00002000",
                     mem_req, mem_be, mem_wdata, mem_we, mem_addr);
        end
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h0000_00AB || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL sh_done: done=%b load=%h req=%b want 1 000000ab 0", done, load_data, mem_req);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_delayed_grant();
        step();
        issue(1'b0, 3'd0, 32'h0000_4000, 32'h0);
        mem_rdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            step();
            @(negedge clk);
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || mem_be !== 4'b1111 || mem_we !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL dgnt_hold%0d: req=%b addr=%h be=%b we=%b done=%b want 1 00004000 1111 0 0",
                         c, mem_req, mem_addr, mem_be, mem_we, done);
            end
        end
        step(); mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL dgnt_wait: req=%b done=%b want 0 0", mem_req, done);
        end
        mem_rvalid = 1'b1;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h1234_5678 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL dgnt_done: done=%b load=%h to=%b want 1 12345678 0", done, load_data, timeout_err);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        step();
        issue(1'b0, 3'd2, 32'h0000_5001, 32'h0);
        mem_rdata = 32'h0000_CD00;
        step(); mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        issue(1'b0, 3'd3, 32'h0000_5002, 32'h0);
        mem_rdata = 32'h7BCD_0000;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h0000_00CD) begin
            bad++; $display("FAIL b2b_first: done=%b load=%h want 1 000000cd", done, load_data);
        end
        step();
        @(negedge clk);
        total++;
        if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1) begin
            bad++; $display("FAIL b2b_idle: done=%b req=%b stall=%b want 0 0 1", done, mem_req, stall);
        end
        step(); mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1100 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_req: req=%b be=%b done=%b want 1 1100 0", mem_req, mem_be, done);
        end
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h0000_7BCD) begin
            bad++; $display("FAIL b2b_second: done=%b load=%h want 1 00007bcd", done, load_data);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_misaligned();
        logic seen_req;
        seen_req = 1'b0;
        step();
        issue(1'b0, 3'd0, 32'h0000_3001, 32'h0);
        @(negedge clk);
        seen_req |= mem_req;
        step();
        @(negedge clk);
        seen_req |= mem_req;
        total++;
        if (done !== 1'b1 || misaligned !== 1'b1 || load_data !== 32'h0000_7BCD) begin
            bad++;
            $display("FAIL mis_word: done=%b mis=%b load=%h want 1 1 00007bcd", done, misaligned, load_data);
        end
        issue(1'b0, 3'd3, 32'h0000_3003, 32'h0);
        step();
        @(negedge clk);
        seen_req |= mem_req;
        step();
        @(negedge clk);
        seen_req |= mem_req;
        total++;
        if (done !== 1'b1 || misaligned !== 1'b1 || load_data !== 32'h0000_7BCD) begin
            bad++;
            $display("FAIL mis_half: done=%b mis=%b load=%h want 1 1 00007bcd", done, misaligned, load_data);
        end
        req_valid = 1'b0;
        step();
        @(negedge clk);
        seen_req |= mem_req;
        total++;
        if (seen_req !== 1'b0 || misaligned !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mis_noreq: seen_req=%b mis=%b done=%b want 0 0 0", seen_req, misaligned, done);
        end
    endtask

    task automatic test_reset_mid_wait();
        step();
        issue(1'b1, 3'd0, 32'h0000_7000, 32'hCAFE_F00D);
        step(); mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({done, misaligned, timeout_err, mem_req, mem_we, stall} !== 6'b0 ||
            {load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            bad++;
            $display("FAIL rst_wait: done=%b req=%b we=%b load=%h addr=%h wdata=%h be=%b want all 0",
                     done, mem_req, mem_we, load_data, mem_addr, mem_wdata, mem_be);
        end
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step(); mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || mem_req !== 1'b0 || load_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_stray: done=%b req=%b load=%h want 0 0 00000000", done, mem_req, load_data);
        end
        step();
        issue(1'b0, 3'd0, 32'h0000_7004, 32'h0);
        mem_rdata = 32'h55AA_55AA;
        step(); mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || load_data !== 32'h55AA_55AA || mem_addr !== 32'h7004) begin
            bad++;
            $display("FAIL rst_next: done=%b load=%h addr=%h want 1 55aa55aa 00007004", done, load_data, mem_addr);
        end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int  cyc;
        logic got;
        logic req_ok;
        got = 1'b0;
        req_ok = 1'b1;
        cyc = 0;
        step();
        issue(1'b0, 3'd0, 32'h0000_6000, 32'h0);
        mem_rdata = 32'hFFFF_FFFF;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
            else if (mem_req !== 1'b1) req_ok = 1'b0;
        end
        total++;
        if (got !== 1'b1 || cyc != 9) begin
            bad++; $display("FAIL to_latency: done seen=%b at cycle %0d want 1 at 9", got, cyc);
        end
        total++;
        if (timeout_err !== 1'b1 || load_data !== 32'h0 || mem_req !== 1'b0 || req_ok !== 1'b1) begin
            bad++;
            $display("FAIL to_flags: to=%b load=%h req=%b req_held=%b want 1 00000000 0 1",
                     timeout_err, load_data, mem_req, req_ok);
        end
        req_valid = 1'b0;
        step(); mem_rvalid = 1'b1;
        step(); mem_rvalid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got |= done;
            step();
        end
        total++;
        if (got !== 1'b0 || load_data !== 32'h0) begin
            bad++; $display("FAIL to_stray: done seen=%b load=%h want 0 00000000", got, load_data);
        end
    endtask

    initial begin
        test_reset();
        test_lbu();
        test_half_store();
        test_delayed_grant();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
